trace_buf: RTL and testbench
============================

Name: trace_buf

Overview:
- Debug trace capture stage directly downstream of the CPU core's debug outputs (pc, instr, arg, acc).
- Records one snapshot per clock into a circular buffer.
- Stops a programmable number of cycles after a PC-match trigger.
- Unloads the captured history oldest-first over a valid/ready read port to a host or logic analyser interface.

Parameters:
- WIDTH, 8, width of each traced field (pc, instr, arg, acc).
- DEPTH, 16, number of snapshot entries; power of two.
- PTR_W, 4, log2(DEPTH); pointer and post-count width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  single-cycle pulse: clear buffer, start pre-trigger capture.
- trig_en  in  1  enables PC-match trigger.
- trig_pc  in  WIDTH  PC value that fires the trigger.
- post_cnt  in  PTR_W  samples captured after the trigger sample; latched when the trigger fires.
- pc  in  WIDTH  core program counter.
- instr  in  WIDTH  core instruction byte.
- arg  in  WIDTH  core argument byte.
- acc  in  WIDTH  core accumulator.
- rd_ready  in  1  consumer accepts current entry.
- rd_valid  out  1  entry presented on rd_* is valid.
- rd_pc, rd_instr, rd_arg, rd_acc  out  WIDTH each  oldest unread snapshot.
- fill  out  PTR_W+1  entries currently held (0..DEPTH).
- state  out  2  0=IDLE, 1=PRE, 2=POST, 3=DONE.
- triggered  out  1  high from trigger until the next arm or return to IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; wr_ptr, fill, post_left and triggered all 0; rd_valid=0.
  - Memory contents are don't-care.
  - Reset mid-capture or mid-readout discards everything.
- Snapshot: {pc,instr,arg,acc} as sampled at the clock edge, written at wr_ptr.
  - wr_ptr increments mod DEPTH.
  - fill increments, saturating at DEPTH; overwriting the oldest entry when full is normal.
- IDLE: no writes; rd_valid=0. arm -> PRE with wr_ptr=0, fill=0. The arm cycle itself writes nothing.
- PRE: writes every cycle. If trig_en && pc==trig_pc:
  - the matching sample is written in that same cycle;
  - triggered<=1, post_left<=post_cnt;
  - next state POST, or DONE if post_cnt==0.
- POST: writes every cycle; post_left decrements per write. The write that takes post_left 1->0 is the last, then -> DONE. Exactly post_cnt samples follow the trigger sample.
- DONE:
  - Read pointer is rd_ptr = (wr_ptr - fill) mod DEPTH, i.e. the oldest entry.
  - rd_valid = (fill!=0); rd_* driven from memory[rd_ptr].
  - Transfer occurs when rd_valid && rd_ready: fill decrements, so the next-oldest entry is presented the following cycle.
  - rd_* are stable while rd_valid && !rd_ready.
  - When fill reaches 0 -> IDLE, triggered<=0.
- No writes occur in DONE or IDLE. Trigger compare is ignored outside PRE.
- arm has priority over everything in any state. It clears wr_ptr, fill, post_left and triggered, and goes to PRE. A pending read transfer in the same cycle is dropped.
- Trigger match in the same cycle as arm is ignored; arm wins.
- trig_en=0 in PRE: capture wraps indefinitely until arm or reset.
- Arithmetic: pointers wrap mod DEPTH. fill is one bit wider, so DEPTH is representable.

Test Plan:
- Reset: assert rst_n=0 mid-POST, release -> state=0, fill=0, rd_valid=0, triggered=0 immediately, without waiting for a clock.
- Wrap capture: arm, then pc=0..22 one per cycle; trig_pc=19, trig_en=1, post_cnt=3 -> DONE after the pc=22 write, fill=16, readout (rd_ready=1) gives pc 7..22 in order, then IDLE.
- Short capture: arm, first sample pc=5 matches, post_cnt=2, pc 5,6,7 -> fill=3, reads pc 5,6,7 with matching instr/arg/acc, then rd_valid=0.
- post_cnt=0: trigger at pc=0x40 after 4 pre-samples -> DONE next cycle, fill=5, last read entry pc=0x40.
- Backpressure: in DONE hold rd_ready=0 for 3 cycles -> rd_* and fill unchanged. Raise for 1 cycle -> exactly one entry consumed.
- Re-arm mid-readout: after 2 of 8 entries read, pulse arm -> state=PRE, fill=0, rd_valid=0, triggered=0. New capture proceeds normally.

Source files
------------

// File: rtl/trace_buf.sv
// trace_buf: circular debug-trace capture with PC-match trigger and oldest-first valid/ready readout
module trace_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             trig_en,
  input  logic [WIDTH-1:0] trig_pc,
  input  logic [PTR_W-1:0] post_cnt,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] instr,
  input  logic [WIDTH-1:0] arg,
  input  logic [WIDTH-1:0] acc,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_pc,
  output logic [WIDTH-1:0] rd_instr,
  output logic [WIDTH-1:0] rd_arg,
  output logic [WIDTH-1:0] rd_acc,
  output logic [PTR_W:0]   fill,
  output logic [1:0]       state,
  output logic             triggered
);
  typedef enum logic [1:0] {IDLE, PRE, POST, DONE} state_t;
  localparam logic [PTR_W:0] full_cnt = (PTR_W+1)'(DEPTH);
  state_t st;
  logic [PTR_W-1:0] wr_ptr, post_left, rd_ptr;
  logic [4*WIDTH-1:0] mem [DEPTH];
  logic we, hit, xfer;
  assign we = !arm && (st == PRE || st == POST);
  assign hit = trig_en && pc == trig_pc;
  // fill==DEPTH leaves the low bits zero, so the oldest entry is wr_ptr itself
  assign rd_ptr = wr_ptr - fill[PTR_W-1:0];
  assign rd_valid = st == DONE && fill != '0;
  assign xfer = rd_valid && rd_ready;
  assign {rd_pc, rd_instr, rd_arg, rd_acc} = mem[rd_ptr];
  assign state = st;
  always_ff @(posedge clk)
    if (we) mem[wr_ptr] <= {pc, instr, arg, acc};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st        <= IDLE;
      wr_ptr    <= '0;
      fill      <= '0;
      post_left <= '0;
      triggered <= 1'b0;
    end else if (arm) begin
      st        <= PRE;
      wr_ptr    <= '0;
      fill      <= '0;
      post_left <= '0;
      triggered <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        fill   <= fill == full_cnt ? fill : fill + (PTR_W+1)'(1);
      end
      case (st)
        PRE: if (hit) begin
          triggered <= 1'b1;
          post_left <= post_cnt;
          st        <= post_cnt == '0 ? DONE : POST;
        end
        POST: begin
          post_left <= post_left - PTR_W'(1);
          if (post_left == PTR_W'(1)) st <= DONE;
        end
        DONE: begin
          if (xfer) fill <= fill - (PTR_W+1)'(1);
          if (fill == '0 || (xfer && fill == (PTR_W+1)'(1))) begin
            st        <= IDLE;
            triggered <= 1'b0;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_trace_buf.sv
// tb_trace_buf: randomized and directed checks of trace_buf against a queue-based reference model
module tb_trace_buf;
  localparam int W = 8, D = 16, P = 4;
  typedef logic [31:0] snap_t;
  logic clk = 0, rst_n = 0, arm = 0, trig_en = 0, rd_ready = 0;
  logic [W-1:0] trig_pc = '0, pc = '0, instr = '0, arg = '0, acc = '0;
  logic [P-1:0] post_cnt = '0;
  logic rd_valid, triggered;
  logic [W-1:0] rd_pc, rd_instr, rd_arg, rd_acc;
  logic [P:0] fill;
  logic [1:0] state;
  int checks = 0, errors = 0;
  snap_t mb[$], sb[$];
  int m_state = 0, m_post = 0;
  bit m_trig = 0;

  trace_buf #(.WIDTH(W), .DEPTH(D), .PTR_W(P)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc),
    .post_cnt(post_cnt), .pc(pc), .instr(instr), .arg(arg), .acc(acc),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instr(rd_instr),
    .rd_arg(rd_arg), .rd_acc(rd_acc), .fill(fill), .state(state), .triggered(triggered)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mb.delete();
    sb.delete();
    m_state = 0;
    m_post = 0;
    m_trig = 0;
  endtask

  task automatic set_snap(input logic [W-1:0] p);
    pc = p;
    instr = W'($urandom);
    arg = W'($urandom);
    acc = W'($urandom);
  endtask

  // one clock: advance the model on the sampled inputs, then compare visible state
  task automatic tick();
    snap_t s;
    @(posedge clk);
    s = {pc, instr, arg, acc};
    if (arm) begin
      model_reset();
      m_state = 1;
    end else case (m_state)
      1, 2: begin
        mb.push_back(s);
        if (mb.size() > D) void'(mb.pop_front());
        if (m_state == 1) begin
          if (trig_en && pc == trig_pc) begin
            m_trig = 1;
            m_post = int'(post_cnt);
            m_state = post_cnt == 0 ? 3 : 2;
          end
        end else begin
          m_post--;
          if (m_post == 0) m_state = 3;
        end
        if (m_state == 3) sb = mb;
      end
      3: if (rd_ready && mb.size() > 0) begin
        void'(mb.pop_front());
        if (mb.size() == 0) begin
          m_state = 0;
          m_trig = 0;
        end
      end
      default: ;
    endcase
    #1;
    chk("state", 32'(state), m_state);
    chk("fill", 32'(fill), mb.size());
    chk("triggered", 32'(triggered), 32'(m_trig));
    chk("rd_valid", 32'(rd_valid), 32'(m_state == 3 && mb.size() > 0));
    if (m_state == 3 && mb.size() > 0) chk("rd_head", {rd_pc, rd_instr, rd_arg, rd_acc}, mb[0]);
  endtask

  task automatic do_arm();
    arm = 1;
    tick();
    arm = 0;
  endtask

  task automatic drain(input int max);
    rd_ready = 1;
    for (int i = 0; i < max && m_state == 3; i++) tick();
    rd_ready = 0;
    chk("drain_idle", 32'(state), 0);
    chk("drain_sb_left", sb.size(), 0);
  endtask

  // scoreboard monitor: every accepted entry must be the next expected snapshot
  always @(negedge clk) begin : monitor
    snap_t e;
    if (rst_n && rd_valid && rd_ready && !arm) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_extra got=%0h want=none", {rd_pc, rd_instr, rd_arg, rd_acc});
      end else begin
        e = sb.pop_front();
        chk("rd_data", {rd_pc, rd_instr, rd_arg, rd_acc}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_state", 32'(state), 0);
    chk("rst_fill", 32'(fill), 0);
    chk("rst_valid", 32'(rd_valid), 0);
    chk("rst_trig", 32'(triggered), 0);
    rst_n = 1;
    tick();
    // wrap capture
    do_arm();
    trig_en = 1; trig_pc = 19; post_cnt = 3;
    for (int p = 0; p <= 22; p++) begin
      set_snap(W'(p));
      tick();
    end
    chk("wrap_state", 32'(state), 3);
    chk("wrap_fill", 32'(fill), 16);
    chk("wrap_first", 32'(rd_pc), 7);
    drain(40);
    // short capture, trigger on first sample
    do_arm();
    trig_pc = 5; post_cnt = 2;
    for (int p = 5; p <= 7; p++) begin
      set_snap(W'(p));
      tick();
    end
    chk("short_fill", 32'(fill), 3);
    chk("short_first", 32'(rd_pc), 5);
    drain(10);
    chk("short_valid", 32'(rd_valid), 0);
    // post_cnt = 0 with backpressure
    do_arm();
    trig_pc = 8'h40; post_cnt = 0;
    for (int p = 1; p <= 4; p++) begin
      set_snap(W'(p));
      tick();
    end
    set_snap(8'h40);
    tick();
    chk("pc0_state", 32'(state), 3);
    chk("pc0_fill", 32'(fill), 5);
    begin
      snap_t h;
      h = {rd_pc, rd_instr, rd_arg, rd_acc};
      repeat (3) tick();
      chk("bp_hold", {rd_pc, rd_instr, rd_arg, rd_acc}, h);
      chk("bp_fill", 32'(fill), 5);
    end
    rd_ready = 1;
    tick();
    rd_ready = 0;
    chk("bp_one", 32'(fill), 4);
    tick();
    chk("bp_one_hold", 32'(fill), 4);
    drain(10);
    // re-arm mid-readout
    do_arm();
    trig_pc = 8'h80; post_cnt = 7;
    for (int p = 8'h80; p <= 8'h87; p++) begin
      set_snap(W'(p));
      tick();
    end
    chk("rearm_fill8", 32'(fill), 8);
    rd_ready = 1;
    repeat (2) tick();
    chk("rearm_fill6", 32'(fill), 6);
    do_arm();
    rd_ready = 0;
    chk("rearm_state", 32'(state), 1);
    chk("rearm_fill", 32'(fill), 0);
    chk("rearm_valid", 32'(rd_valid), 0);
    chk("rearm_trig", 32'(triggered), 0);
    trig_pc = 3; post_cnt = 1;
    for (int p = 1; p <= 4; p++) begin
      set_snap(W'(p));
      tick();
    end
    chk("rearm_new_fill", 32'(fill), 4);
    drain(10);
    // asynchronous reset mid-POST
    do_arm();
    trig_pc = 9; post_cnt = 10;
    set_snap(9);
    tick();
    set_snap(10);
    tick();
    chk("pre_rst_state", 32'(state), 2);
    #2 rst_n = 0;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_fill", 32'(fill), 0);
    chk("arst_valid", 32'(rd_valid), 0);
    chk("arst_trig", 32'(triggered), 0);
    model_reset();
    #2 rst_n = 1;
    repeat (2) tick();
    // randomized traffic
    repeat (3000) begin
      arm = (m_state == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
      trig_en = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 15) == 0) begin
        trig_pc = W'($urandom_range(0, 15));
        post_cnt = P'($urandom);
      end
      set_snap(W'($urandom_range(0, 15)));
      rd_ready = $urandom_range(0, 1) == 1;
      tick();
      arm = 0;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
